// File: rtl/i_cache_direct.sv
// Direct-mapped, read-only instruction cache with a 4-word line and single-outstanding refill.
// Hits answer combinationally in IDLE; misses hold one line refill open in FILL until memory returns.
module i_cache_direct #(
  parameter int LINES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        flush,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 14 - INDEX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_reg;
  logic [LINES-1:0]   valid_reg;
  logic               mem_read_reg;
  logic [15:0]        mem_addr_reg;
  logic               flush_pend_reg;
  logic [15:0]        hit_cnt_reg;
  logic [15:0]        miss_cnt_reg;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [63:0]        data_mem [LINES];

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [63:0]        rd_line;
  logic [15:0]        line_words [4];
  logic               lookup;
  logic               line_match;
  logic               hit;
  logic               miss;
  logic               fill_done;

  assign req_index  = cpu_addr[INDEX_W+1:2];
  assign req_tag    = cpu_addr[15:INDEX_W+2];
  assign fill_index = mem_addr_reg[INDEX_W+1:2];
  assign fill_tag   = mem_addr_reg[15:INDEX_W+2];

  // Flush outranks a lookup, so a flushing cycle neither hits nor starts a refill.
  assign lookup     = (state_reg == IDLE) && cpu_req && !flush;
  assign line_match = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
  assign hit        = lookup && line_match;
  assign miss       = lookup && !line_match;
  assign fill_done  = (state_reg == FILL) && mem_ready;

  assign rd_line = data_mem[req_index];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_words
      assign line_words[gi] = rd_line[16*gi +: 16];
    end
  endgenerate

  assign cpu_ready  = hit;
  assign cpu_rdata  = hit ? line_words[cpu_addr[1:0]] : 16'h0000;
  assign mem_read   = mem_read_reg;
  assign mem_addr   = mem_addr_reg;
  assign hit_count  = hit_cnt_reg;
  assign miss_count = miss_cnt_reg;

  // Line storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[fill_index] <= mem_rdata;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      mem_read_reg   <= 1'b0;
      mem_addr_reg   <= 16'h0000;
      flush_pend_reg <= 1'b0;
      hit_cnt_reg    <= 16'h0000;
      miss_cnt_reg   <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush) begin
            valid_reg <= '0;
          end else if (hit) begin
            if (hit_cnt_reg != 16'hFFFF) hit_cnt_reg <= hit_cnt_reg + 16'd1;
          end else if (miss) begin
            if (miss_cnt_reg != 16'hFFFF) miss_cnt_reg <= miss_cnt_reg + 16'd1;
            mem_addr_reg <= {cpu_addr[15:2], 2'b00};
            mem_read_reg <= 1'b1;
            state_reg    <= FILL;
          end
        end
        FILL: begin
          if (flush) flush_pend_reg <= 1'b1;
          if (mem_ready) begin
            mem_read_reg   <= 1'b0;
            flush_pend_reg <= 1'b0;
            state_reg      <= IDLE;
            // A flush seen at any point of the refill also discards the line just filled.
            if (flush_pend_reg || flush) valid_reg <= '0;
            else                         valid_reg[fill_index] <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i_cache_direct.md
I_CACHE_DIRECT -- requirements
Module: i_cache_direct

Interface
REQ-001 Parameter LINES, default 8, meaning number of direct-mapped lines (power of 2, 2..64); INDEX_W = log2(LINES).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous and active-high (asserted = 1), despite the codebase port name.
REQ-004 cpu_req  input  1  CPU requests an instruction word this cycle.
REQ-005 cpu_addr  input  16  word address; [1:0] word offset, [INDEX_W+1:2] index, [15:INDEX_W+2] tag.
REQ-006 cpu_rdata  output  16  instruction word; valid only when cpu_ready=1.
REQ-007 cpu_ready  output  1  hit response for the current cpu_req/cpu_addr.
REQ-008 flush  input  1  invalidate all lines.
REQ-009 mem_read  output  1  line refill request to memory.
REQ-010 mem_addr  output  16  line-aligned word address {tag,index,2'b00}.
REQ-011 mem_rdata  input  64  line data; word k at bits [16k+15:16k].
REQ-012 mem_ready  input  1  mem_rdata valid this cycle for the outstanding mem_read.
REQ-013 hit_count, miss_count  output  16 each  saturating event counters.

Function
REQ-014 Storage: per line a valid bit, tag, 64-bit data; read-only cache, no write port toward memory.
REQ-015 FSM states IDLE, FILL; reset state IDLE.
REQ-016 IDLE, cpu_req=1, flush=0, valid[index] and tag match: cpu_ready=1 combinationally the same cycle, cpu_rdata = selected word; hit_count +1 at clock edge.
REQ-017 IDLE, cpu_req=1, flush=0, miss: cpu_ready=0; latch line address; next state FILL; miss_count +1.
REQ-018 FILL: mem_read=1, mem_addr = latched line address, both stable until mem_ready sampled 1; cpu_ready=0 regardless of cpu_req.
REQ-019 FILL with mem_ready=1: write data and tag, set valid, next state IDLE; the re-presented request hits the following cycle (miss penalty = memory wait + 2 cycles).
REQ-020 cpu_addr changes during FILL: refill still completes for the latched address; the new address is evaluated on return to IDLE.
REQ-021 flush in IDLE: all valid bits cleared at the edge; flush has priority over a simultaneous cpu_req (cpu_ready=0, no counter change).
REQ-022 flush during FILL: latched as pending; refill completes, then the filled line and all others are invalid on entry to IDLE; pending cleared.
REQ-023 mem_ready while in IDLE is ignored.
REQ-024 Counters saturate at 16'hFFFF; never wrap.
REQ-025 cpu_rdata = 16'h0000 when cpu_ready=0.

Reset
REQ-026 reset_n=1 asynchronously: state IDLE, all valid bits 0, mem_read=0, mem_addr=0, cpu_ready=0, counters 0, pending flush 0; data/tag arrays need not be cleared.
REQ-027 Reset mid-FILL drops mem_read in the same instant; a late mem_ready after release is ignored.

Verification
REQ-028 Cold read cpu_addr=16'h0005, memory returns line 16'h0004 = 64'h4444_3333_2222_1111 after 3 wait cycles -> mem_addr=16'h0004 held, then next IDLE cycle cpu_ready=1, cpu_rdata=16'h2222, miss_count=1, hit_count=1.
REQ-029 LINES=8, read 16'h0000 then 16'h0020 (same index, different tag) then 16'h0000 -> three misses, miss_count=3.
REQ-030 Sequential reads 16'h0004..16'h0007 after one fill -> 1 miss, 4 hits, cpu_ready=1 each cycle.
REQ-031 flush asserted with cpu_req on a resident line -> cpu_ready=0 that cycle, next request misses; flush during FILL -> line invalid after fill completes.
REQ-032 reset_n pulsed during FILL, then mem_ready=1 -> mem_read=0, no valid line written, counters 0.
REQ-033 Drive 65540 hits -> hit_count=16'hFFFF.
